// File: rtl/scl_spare_mon_pkg.sv
// -----------------------------------------------------------------------------
// scl_spare_mon_pkg
// Shared definitions for the spare-cell tie-low monitor:
//   - scan FSM state encoding
//   - default values for the monitor parameters
//   - debounce counter width and its next-value helper
// Optional feature macro used by the top: SCL_SPARE_MON_AUTO_EN.
// -----------------------------------------------------------------------------
package scl_spare_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC0 = 3'd1,
      ST_SYNC1 = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int NUM_CELLS_DEF   = 4;
   localparam int DEBOUNCE_DEF    = 3;
   localparam int CNT_W_DEF       = 8;
   localparam int AUTO_PERIOD_DEF = 256;

   // Wide enough for the largest legal debounce limit (7).
   localparam int DCNT_W = 3;

   // Debounce step: a high sample counts up and saturates at lim, a low
   // sample restarts the count.
   function automatic logic [DCNT_W-1:0] dcnt_step(
      input logic [DCNT_W-1:0] cur,
      input logic [DCNT_W-1:0] lim,
      input logic              hi
   );
      logic [DCNT_W-1:0] nxt;
      if (!hi) begin
         nxt = {DCNT_W{1'b0}};
      end else if (cur >= lim) begin
         nxt = lim;
      end else begin
         nxt = cur + {{(DCNT_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/scl_sync2.sv
// -----------------------------------------------------------------------------
// scl_sync2
// Free-running two-flop synchronizer, WIDTH bits wide.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears both flop stages
//   d    - asynchronous input bits
//   q    - synchronized output bits (two clk cycles of latency)
// -----------------------------------------------------------------------------
module scl_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two flop stages; the first may go metastable, the second settles it.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/scl_spare_tie_monitor.sv
// -----------------------------------------------------------------------------
// scl_spare_tie_monitor
// Periodically scans the LO outputs of spare-cell tie macros. A cell whose LO
// output reads high on DEBOUNCE consecutive scans is flagged in a sticky fault
// map and counted. A scan is IDLE -> SYNC0 -> SYNC1 -> SCAN (NUM_CELLS
// cycles, one cell per cycle in ascending order) -> DONE.
// Optional feature: define SCL_SPARE_MON_AUTO_EN to add a free-running
// interval counter that requests a scan every AUTO_PERIOD cycles.
// Ports:
//   wb_clk_i     - clock
//   wb_rst_i     - synchronous active-high reset
//   tie_lo_i     - spare-cell LO outputs (asynchronous)
//   start_i      - one-cycle scan request (ignored unless idle)
//   clr_i        - clear sticky fault state and debounce counters
//   busy_o       - scan in progress
//   done_o       - one-cycle pulse at scan completion
//   fault_map_o  - sticky per-cell fault flags
//   fault_cnt_o  - faults declared since last clear (saturating)
//   fault_o      - OR of the fault map
// -----------------------------------------------------------------------------
module scl_spare_tie_monitor
   import scl_spare_mon_pkg::*;
#(
   parameter int NUM_CELLS   = NUM_CELLS_DEF,
   parameter int DEBOUNCE    = DEBOUNCE_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int AUTO_PERIOD = AUTO_PERIOD_DEF
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [NUM_CELLS-1:0] tie_lo_i,
   input  logic                 start_i,
   input  logic                 clr_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [NUM_CELLS-1:0] fault_map_o,
   output logic [CNT_W-1:0]     fault_cnt_o,
   output logic                 fault_o
);

   localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CELLS - 1);
   localparam logic [DCNT_W-1:0] DB_LIM   = DCNT_W'(DEBOUNCE);

   logic [NUM_CELLS-1:0] tie_sync_s;
   state_e               state_r;
   state_e               state_s;
   logic [IDX_W-1:0]     idx_r;
   logic [IDX_W-1:0]     idx_s;
   logic [DCNT_W-1:0]    dcnt_r [NUM_CELLS];
   logic [DCNT_W-1:0]    cell_dcnt_s;
   logic                 scan_s;
   logic                 hit_s;
   logic                 start_s;
   logic                 auto_start_s;
   logic                 busy_r;
   logic                 done_r;
   logic [NUM_CELLS-1:0] map_r;
   logic [NUM_CELLS-1:0] map_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_s;
   logic                 fault_r;

   scl_sync2 #(
      .WIDTH (NUM_CELLS)
   ) u_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (tie_lo_i),
      .q   (tie_sync_s)
   );

`ifdef SCL_SPARE_MON_AUTO_EN
   localparam int AP_W = $clog2(AUTO_PERIOD);
   localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

   logic [AP_W-1:0] auto_cnt_r;

   // Free-running interval counter; wraps every AUTO_PERIOD cycles.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         auto_cnt_r <= {AP_W{1'b0}};
      end else if (auto_cnt_r == AP_LAST) begin
         auto_cnt_r <= {AP_W{1'b0}};
      end else begin
         auto_cnt_r <= auto_cnt_r + {{(AP_W-1){1'b0}}, 1'b1};
      end
   end

   // A tick that lands while a scan is running is dropped, not held.
   assign auto_start_s = (auto_cnt_r == AP_LAST) && !busy_r;
`else
   assign auto_start_s = 1'b0;
`endif

   assign start_s = start_i | auto_start_s;

   // Scan sequencing: next state and cell index.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_SYNC0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SYNC0: state_s = ST_SYNC1;
         ST_SYNC1: begin
            state_s = ST_SCAN;
            idx_s   = {IDX_W{1'b0}};
         end
         ST_SCAN: begin
            if (idx_r == LAST_IDX) begin
               state_s = ST_DONE;
               idx_s   = {IDX_W{1'b0}};
            end else begin
               idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: begin
            state_s = ST_IDLE;
            idx_s   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Fault evaluation for the cell under scan; clr_i overrides any new fault.
   always_comb begin
      scan_s      = (state_r == ST_SCAN);
      cell_dcnt_s = dcnt_step(dcnt_r[idx_r], DB_LIM, tie_sync_s[idx_r]);
      hit_s       = scan_s && (cell_dcnt_s == DB_LIM) && !map_r[idx_r];
      map_s       = map_r;
      cnt_s       = cnt_r;
      if (clr_i) begin
         map_s = {NUM_CELLS{1'b0}};
         cnt_s = {CNT_W{1'b0}};
      end else if (hit_s) begin
         map_s[idx_r] = 1'b1;
         if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_s = cnt_r;
         end
      end else begin
         map_s = map_r;
         cnt_s = cnt_r;
      end
   end

   // FSM state, index and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
         idx_r   <= {IDX_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         map_r   <= {NUM_CELLS{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         fault_r <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= (state_s == ST_DONE);
         map_r   <= map_s;
         cnt_r   <= cnt_s;
         fault_r <= |map_s;
      end
   end

   // Per-cell debounce counters; only the cell under scan is updated.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clr_i) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            dcnt_r[i] <= {DCNT_W{1'b0}};
         end
      end else if (scan_s) begin
         dcnt_r[idx_r] <= cell_dcnt_s;
      end
   end

   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign fault_map_o = map_r;
   assign fault_cnt_o = cnt_r;
   assign fault_o     = fault_r;

endmodule
